// File: rtl/elastic_pkg.sv
// rtl/elastic_pkg.sv - shared types and helpers for elastic channel arbiters
package elastic_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - rotating first-one finder starting at ptr
module rr_priority_encoder #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                idx = W'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elastic_rr_arbiter.sv
// rtl/elastic_rr_arbiter.sv - round-robin arbiter onto one elastic valid/ready channel
module elastic_rr_arbiter
    import elastic_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 1,
    localparam int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [NUM_IN*DATA_WIDTH-1:0] din,
    input  logic [NUM_IN-1:0]            din_v,
    output logic [NUM_IN-1:0]            din_r,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         dout_v,
    input  logic                         dout_r,
    output logic [SEL_W-1:0]             dout_sel
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    arb_state_e       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt_q;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] enc_idx;
    logic             enc_any;
    logic             kill;

    assign kill = rst | clr;

    rr_priority_encoder #(
        .N(NUM_IN),
        .W(SEL_W)
    ) u_enc (
        .req(din_v),
        .ptr(ptr),
        .idx(enc_idx),
        .any(enc_any)
    );

    always_ff @(posedge clk) begin
        if (kill) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            gnt_q <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (enc_any) begin
                        if (!dout_r) begin
                            // Stalled offer: freeze the grant so dout never retracts.
                            gnt_q <= enc_idx;
                            cnt   <= '0;
                            state <= ARB_LOCK;
                        end else if (BURST_LEN == 1) begin
                            ptr <= SEL_W'(rr_next(int'(enc_idx), NUM_IN));
                        end else begin
                            gnt_q <= enc_idx;
                            cnt   <= CNT_W'(1);
                            state <= ARB_LOCK;
                        end
                    end
                end
                ARB_LOCK: begin
                    if (!din_v[gnt_q]) begin
                        ptr   <= SEL_W'(rr_next(int'(gnt_q), NUM_IN));
                        cnt   <= '0;
                        state <= ARB_IDLE;
                    end else if (dout_r) begin
                        if (cnt == CNT_LAST) begin
                            ptr   <= SEL_W'(rr_next(int'(gnt_q), NUM_IN));
                            cnt   <= '0;
                            state <= ARB_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        sel      = (state == ARB_LOCK) ? gnt_q : enc_idx;
        din_r    = '0;
        dout     = '0;
        dout_v   = 1'b0;
        dout_sel = '0;
        if (!kill) begin
            dout_sel = sel;
            dout     = din[sel*DATA_WIDTH +: DATA_WIDTH];
            dout_v   = (state == ARB_LOCK) ? din_v[gnt_q] : enc_any;
            if (state == ARB_LOCK || enc_any)
                din_r[sel] = dout_r;
        end
    end

endmodule
